// File: rtl/changesign_multi.sv
// Multi-channel two's-complement to sign/magnitude converter with most-negative
// saturation, deadband sign hold, run-time magnitude clamp and a saturation counter.
module changesign_multi #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int DEADBAND = 0,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-2:0]          cfg_limit,
  output logic [CHANNELS*WIDTH-1:0] out_mag,
  output logic [CHANNELS-1:0]       out_sign,
  output logic [CHANNELS-1:0]       out_sat,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          sat_count
);
  localparam int MW = WIDTH - 1;

  logic s1_valid;
  logic s2_can_load;
  logic s2_load;
  logic in_xfer;
  logic out_xfer;

  // Handshake: a beat moves when valid && ready on that side. Stage 2 may load
  // whenever its output slot is empty or being drained this cycle, and the input
  // is ready whenever stage 1 is empty or will hand off; the only combinational
  // input-to-output path is out_ready -> in_ready.
  assign s2_can_load = !out_valid || out_ready;
  assign in_ready    = !s1_valid || s2_can_load;
  assign in_xfer     = in_valid && in_ready;
  assign out_xfer    = out_valid && out_ready;
  assign s2_load     = s1_valid && s2_can_load;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] neg_x;
    logic [MW-1:0]    conv_mag;
    logic             conv_sat;
    logic [MW-1:0]    s1_mag;
    logic             s1_neg;
    logic             s1_sat;
    logic             in_db;
    logic [MW-1:0]    mag_q;
    logic             sign_q;
    logic             sat_q;
    logic             held_sign;

    assign x     = in_data[k*WIDTH +: WIDTH];
    assign neg_x = -x;

    // The most-negative value has no positive counterpart; it saturates to full scale.
    always_comb begin
      conv_mag = x[MW-1:0];
      conv_sat = 1'b0;
      if (x[WIDTH-1]) begin
        if (x[MW-1:0] == '0) begin
          conv_mag = '1;
          conv_sat = 1'b1;
        end else begin
          conv_mag = neg_x[MW-1:0];
        end
      end
    end

    if (DEADBAND > 0) begin : g_db
      assign in_db = s1_mag < MW'(DEADBAND);
    end else begin : g_no_db
      assign in_db = 1'b0;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_mag    <= '0;
        s1_neg    <= 1'b0;
        s1_sat    <= 1'b0;
        mag_q     <= '0;
        sign_q    <= 1'b0;
        sat_q     <= 1'b0;
        held_sign <= 1'b0;
      end else begin
        if (in_xfer) begin
          s1_mag <= conv_mag;
          s1_neg <= x[WIDTH-1];
          s1_sat <= conv_sat;
        end
        if (s2_load) begin
          if (in_db) begin
            // Small magnitudes keep the last confident sign to avoid sign chatter.
            mag_q  <= '0;
            sign_q <= held_sign;
            sat_q  <= s1_sat;
          end else if (s1_mag > cfg_limit) begin
            mag_q     <= cfg_limit;
            sign_q    <= s1_neg;
            sat_q     <= 1'b1;
            held_sign <= s1_neg;
          end else begin
            mag_q     <= s1_mag;
            sign_q    <= s1_neg;
            sat_q     <= s1_sat;
            held_sign <= s1_neg;
          end
        end
      end
    end

    assign out_mag[k*WIDTH +: WIDTH] = {1'b0, mag_q};
    assign out_sign[k]               = sign_q;
    assign out_sat[k]                = sat_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      sat_count <= '0;
    end else begin
      if (in_xfer) begin
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
      if (s2_load) begin
        out_valid <= 1'b1;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
      if (out_xfer && (|out_sat) && (sat_count != '1)) begin
        sat_count <= sat_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_changesign_multi.sv
// Directed and randomized bench for changesign_multi with an integer-arithmetic
// reference model feeding an in-order expected queue.
module tb_changesign_multi;
  localparam int WIDTH    = 16;
  localparam int CHANNELS = 2;
  localparam int DEADBAND = 4;
  localparam int CNT_W    = 4;
  localparam int OW       = 2*CHANNELS + CHANNELS*WIDTH;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [CHANNELS*WIDTH-1:0] in_data = '0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [WIDTH-2:0]          cfg_limit = 15'h7FFF;
  logic [CHANNELS*WIDTH-1:0] out_mag;
  logic [CHANNELS-1:0]       out_sign;
  logic [CHANNELS-1:0]       out_sat;
  logic                      out_valid;
  logic                      out_ready = 1'b1;
  logic [CNT_W-1:0]          sat_count;

  changesign_multi #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEADBAND(DEADBAND), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .cfg_limit(cfg_limit), .out_mag(out_mag),
    .out_sign(out_sign), .out_sat(out_sat), .out_valid(out_valid),
    .out_ready(out_ready), .sat_count(sat_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [OW-1:0] exp_q[$];
  bit            held[2];
  int            model_cnt;
  int            checks;
  int            errors;
  int            out_count;
  bit            last_acc;
  bit            stall_prev;
  logic [OW-1:0] stall_snap;
  bit            saw_in_ready_low;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed integer -> |value|, saturate to 32767, then deadband / clamp.
  function automatic logic [OW-1:0] model_beat(input logic [31:0] d, input int lim);
    logic [OW-1:0] r;
    r = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      int v;
      int m;
      bit s;
      bit sat;
      v   = $signed(d[k*16 +: 16]);
      s   = (v < 0);
      m   = s ? -v : v;
      sat = 1'b0;
      if (m > 32767) begin
        m   = 32767;
        sat = 1'b1;
      end
      if (m < DEADBAND) begin
        m = 0;
        s = held[k];
      end else if (m > lim) begin
        m       = lim;
        sat     = 1'b1;
        held[k] = s;
      end else begin
        held[k] = s;
      end
      r[k*16 +: 16] = m[15:0];
      r[32 + k]     = s;
      r[34 + k]     = sat;
    end
    return r;
  endfunction

  function automatic logic [15:0] rand_sample();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'($urandom_range(0, 8));
      3:       return 16'(0 - int'($urandom_range(0, 8)));
      default: return 16'($urandom);
    endcase
  endfunction

  // One clock: observe at negedge, update model, advance past the edge.
  task automatic cycle();
    logic [OW-1:0] obs;
    logic [OW-1:0] e;
    @(negedge clk);
    obs      = {out_sat, out_sign, out_mag};
    last_acc = 1'b0;
    if (rst_n) begin
      chk("sat_count", sat_count, model_cnt);
      chk("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
      if (!in_ready) saw_in_ready_low = 1'b1;
      if (stall_prev && out_valid) chk("stall_stable", obs, stall_snap);
      stall_prev = out_valid && !out_ready;
      stall_snap = obs;
      if (out_valid && out_ready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_beat: observed=%0h expected=none", obs);
        end else begin
          e = exp_q.pop_front();
          chk("beat", obs, e);
          if (|e[OW-1 -: 2]) model_cnt = (model_cnt < 15) ? model_cnt + 1 : 15;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_beat(in_data, int'(cfg_limit)));
        last_acc = 1'b1;
      end
    end else begin
      exp_q.delete();
      held       = '{0, 0};
      model_cnt  = 0;
      stall_prev = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    int n;
    in_data  = {b, a};
    in_valid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed=not accepted expected=accepted within 20 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) cycle();
    chk("drain_empty", exp_q.size(), 0);
    cycle();
  endtask

  initial begin
    int idx;
    int base;

    // reset state
    rst_n = 1'b0;
    repeat (2) cycle();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_mag", out_mag, 32'h0);
    chk("rst_out_sign", out_sign, 2'b00);
    chk("rst_out_sat", out_sat, 2'b00);
    chk("rst_sat_count", sat_count, 4'd0);
    rst_n = 1'b1;
    cycle();

    // basic conversion and latency
    send(16'(-300), 16'd1234);
    chk("lat_not_yet", out_valid, 1'b0);
    cycle();
    chk("basic_valid", out_valid, 1'b1);
    chk("basic_mag", out_mag, {16'd1234, 16'd300});
    chk("basic_sign", out_sign, 2'b01);
    chk("basic_sat", out_sat, 2'b00);
    drain();
    chk("basic_count", sat_count, 4'd0);

    // most negative
    send(16'h8000, 16'd5);
    cycle();
    chk("mneg_mag", out_mag, {16'd5, 16'h7FFF});
    chk("mneg_sign", out_sign, 2'b01);
    chk("mneg_sat", out_sat, 2'b01);
    drain();
    chk("mneg_count", sat_count, 4'd1);

    // clamp
    cfg_limit = 15'd1000;
    send(16'(-5000), 16'd999);
    cycle();
    chk("clamp_mag", out_mag, {16'd999, 16'd1000});
    chk("clamp_sign", out_sign, 2'b01);
    chk("clamp_sat", out_sat, 2'b01);
    drain();

    // limit change while stalled does not touch held output
    out_ready = 1'b0;
    send(16'(-5000), 16'd0);
    cycle();
    cfg_limit = 15'd10;
    cycle();
    chk("stall_cfg_mag", out_mag[15:0], 16'd1000);
    drain();
    cfg_limit = 15'h7FFF;

    // deadband sign hold on ch0
    send(16'(-50), 16'd20);
    cycle();
    chk("db1_mag", out_mag[15:0], 16'd50);
    chk("db1_sign", out_sign[0], 1'b1);
    send(16'd3, 16'd0);
    cycle();
    chk("db2_mag", out_mag[15:0], 16'd0);
    chk("db2_sign", out_sign[0], 1'b1);
    send(16'(-2), 16'd0);
    cycle();
    chk("db3_mag", out_mag[15:0], 16'd0);
    chk("db3_sign", out_sign[0], 1'b1);
    send(16'd10, 16'd0);
    cycle();
    chk("db4_sign", out_sign[0], 1'b0);
    drain();

    // backpressure: 6 beats, downstream stalled for cycles 3..7
    idx = 0;
    base = out_count;
    saw_in_ready_low = 1'b0;
    for (int c = 0; c < 60 && (idx < 6 || exp_q.size() > 0); c++) begin
      out_ready = !(c >= 3 && c <= 7);
      in_valid  = (idx < 6);
      in_data   = {16'((idx + 1) * 10), 16'(-((idx + 1) * 7 + 5))};
      cycle();
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    chk("bp_in_ready_fell", saw_in_ready_low, 1'b1);
    chk("bp_accepted", idx, 6);
    chk("bp_emitted", out_count - base, 6);
    drain();

    // randomized traffic
    cfg_limit = 15'd20000;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {rand_sample(), rand_sample()};
      cycle();
    end
    in_valid = 1'b0;
    drain();
    cfg_limit = 15'h7FFF;

    // reset mid-stream with both stages full
    send(16'h8000, 16'h8000);
    drain();
    out_ready = 1'b0;
    send(16'(-100), 16'(-200));
    send(16'(-300), 16'(-400));
    chk("full_in_ready", in_ready, 1'b0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_count", sat_count, 4'd0);
    cycle();
    cycle();
    chk("mid_rst_s1_empty", out_valid, 1'b0);
    out_ready = 1'b1;
    send(16'd2, 16'd0);
    cycle();
    chk("mid_rst_held", out_sign, 2'b00);
    drain();

    // saturation counter stops at 15
    for (int i = 0; i < 20; i++) send(16'h8000, 16'd7);
    drain();
    chk("cnt_sat", sat_count, 4'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
